// File: rtl/dma_write_block.sv
// -----------------------------------------------------------------------------
// dma_write_block
//   Write side of the DMA engine. Write commands {bytes, addr} are queued in a
//   small command FIFO. Each command is turned into one or more AVMM write
//   bursts of at most MAX_BURST 256-bit beats. Beats are taken from a show-ahead
//   data FIFO. A one-cycle done pulse marks the acceptance of a command's final
//   beat.
//
//   Ports
//     clk, reset                    single clock, synchronous active-high reset
//     dma_wr_fifo_command_req_i     push a command {bytes_to_transfer, addr}
//     dma_wr_bytes_to_transfer_i    transfer length in bytes
//     dma_wr_addr_i                 destination byte address (bits [4:0] ignored)
//     dma_wr_fifo_full_o            command FIFO full (registered)
//     dma_wr_data_i / _empty_i      data FIFO head (show-ahead) and empty flag
//     dma_wr_data_rdreq_o           data FIFO pop, one per accepted beat
//     wr_master_*                   AVMM write master (addr, bcount, write,
//                                   data, byteen, wait_req)
//     dma_wr_done_o                 one-cycle pulse per completed command
//
//   Optional build macro DMA_WR_STALL_CNT_EN adds wr_stall_cycles_o, a
//   saturating count of cycles with write_o high and wait_req_i high.
// -----------------------------------------------------------------------------
module dma_write_block #(
    parameter int CMD_FIFO_DEPTH = 32,
    parameter int MAX_BURST      = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         dma_wr_fifo_command_req_i,
    input  logic [15:0]  dma_wr_bytes_to_transfer_i,
    input  logic [31:0]  dma_wr_addr_i,
    output logic         dma_wr_fifo_full_o,
    input  logic [255:0] dma_wr_data_i,
    input  logic         dma_wr_data_empty_i,
    output logic         dma_wr_data_rdreq_o,
    output logic [31:0]  wr_master_addr_o,
    output logic [10:0]  wr_master_bcount_o,
    output logic         wr_master_write_o,
    output logic [255:0] wr_master_data_o,
    output logic [31:0]  wr_master_byteen_o,
    input  logic         wr_master_wait_req_i,
    output logic         dma_wr_done_o
`ifdef DMA_WR_STALL_CNT_EN
    ,
    output logic [31:0]  wr_stall_cycles_o
`endif
);

    localparam int             AW          = $clog2(CMD_FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_W     = CMD_FIFO_DEPTH[AW:0];
    localparam logic [11:0]    MAX_BURST_W = 12'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_CMD,
        S_SETUP,
        S_WRITE,
        S_DONE
    } state_e;

    // ---------------- command FIFO ----------------
    logic [47:0]   cmd_mem [CMD_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q;
    logic          cmd_push, cmd_pop, cmd_empty;
    logic [47:0]   cmd_head;

    assign cmd_push  = dma_wr_fifo_command_req_i & ~full_q;
    assign cmd_empty = (count_q == '0);
    assign cmd_head  = cmd_mem[rd_ptr_q];
    assign count_d   = count_q + {{AW{1'b0}}, cmd_push} - {{AW{1'b0}}, cmd_pop};

    // NOTE: the storage array has no reset; flushing is done by clearing the
    // pointers and count, which keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[wr_ptr_q] <= {dma_wr_bytes_to_transfer_i, dma_wr_addr_i};
        end
    end

    // ---------------- burst engine ----------------
    state_e       state_q, state_d;
    logic [31:0]  cur_addr_q, cur_addr_d;      // start address of the next burst
    logic [11:0]  remaining_q, remaining_d;    // beats not yet assigned to a burst
    logic [4:0]   tail_q, tail_d;
    logic [31:0]  burst_addr_q, burst_addr_d;
    logic [10:0]  burst_len_q, burst_len_d;
    logic [10:0]  beat_cnt_q, beat_cnt_d;      // beats accepted in current burst

    logic         write_req, beat_accept, last_beat, final_beat;
    logic [10:0]  burst_sel;

    assign write_req   = (state_q == S_WRITE) & ~dma_wr_data_empty_i;
    assign beat_accept = write_req & ~wr_master_wait_req_i;
    assign last_beat   = (beat_cnt_q == burst_len_q - 11'd1);
    assign final_beat  = last_beat & (remaining_q == 12'd0);
    assign burst_sel   = (remaining_q > MAX_BURST_W) ? MAX_BURST_W[10:0] : remaining_q[10:0];
    assign cmd_pop     = (state_q == S_LD_CMD);

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        tail_d       = tail_q;
        burst_addr_d = burst_addr_q;
        burst_len_d  = burst_len_q;
        beat_cnt_d   = beat_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (!cmd_empty) state_d = S_LD_CMD;
            end
            S_LD_CMD: begin
                // A partial trailing beat still costs a full beat.
                remaining_d = {1'b0, cmd_head[47:37]} + {11'd0, |cmd_head[36:32]};
                tail_d      = cmd_head[36:32];
                cur_addr_d  = cmd_head[31:0] & 32'hFFFF_FFE0;
                state_d     = S_SETUP;
            end
            S_SETUP: begin
                if (remaining_q == 12'd0) begin
                    state_d = S_DONE;
                end else begin
                    burst_addr_d = cur_addr_q;
                    burst_len_d  = burst_sel;
                    cur_addr_d   = cur_addr_q + {16'd0, burst_sel, 5'd0};
                    remaining_d  = remaining_q - {1'b0, burst_sel};
                    beat_cnt_d   = 11'd0;
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: begin
                if (beat_accept) begin
                    if (last_beat) begin
                        state_d = (remaining_q != 12'd0) ? S_SETUP : S_DONE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 11'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            tail_q       <= '0;
            burst_addr_q <= '0;
            burst_len_q  <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            if (cmd_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (cmd_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q      <= count_d;
            full_q       <= (count_d == DEPTH_W);
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            tail_q       <= tail_d;
            burst_addr_q <= burst_addr_d;
            burst_len_q  <= burst_len_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // ---------------- outputs ----------------
    assign dma_wr_fifo_full_o  = full_q;
    assign dma_wr_data_rdreq_o = beat_accept;
    assign wr_master_write_o   = write_req;
    assign wr_master_addr_o    = burst_addr_q;
    assign wr_master_bcount_o  = burst_len_q;
    assign wr_master_data_o    = write_req ? dma_wr_data_i : '0;
    assign dma_wr_done_o       = (state_q == S_DONE);

    always_comb begin
        wr_master_byteen_o = 32'd0;
        if (write_req) begin
            if (final_beat && (tail_q != 5'd0)) wr_master_byteen_o = ~(32'hFFFF_FFFF << tail_q);
            else                                wr_master_byteen_o = 32'hFFFF_FFFF;
        end
    end

`ifdef DMA_WR_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (write_req && wr_master_wait_req_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign wr_stall_cycles_o = stall_cnt_q;
`endif

endmodule
